// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: allocator FSM encoding,
// WaveGen wave-type codes and default control-word widths.
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  // WaveGen WaveType encoding
  localparam logic [1:0] WAVE_SQUARE   = 2'b00;
  localparam logic [1:0] WAVE_TRIANGLE = 2'b01;
  localparam logic [1:0] WAVE_SAWTOOTH = 2'b10;
  localparam logic [1:0] WAVE_SINE     = 2'b11;

  localparam int DEFAULT_FREQ_WIDTH = 8;
  localparam int DEFAULT_NOTE_WIDTH = 7;

endpackage

// File: rtl/voice_slot.sv
// One voice's state (active, note, frequency, wave, age) plus the note
// compare and saturating age update used by the allocator.
module voice_slot
  import synth_pkg::*;
#(
  parameter int FREQ_WIDTH = DEFAULT_FREQ_WIDTH,
  parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  commit_on_i,
  input  logic                  commit_off_i,
  input  logic                  sel_i,
  input  logic [NOTE_WIDTH-1:0] note_i,
  input  logic [FREQ_WIDTH-1:0] freq_i,
  input  logic [1:0]            wave_i,
  output logic                  active_o,
  output logic                  match_o,
  output logic [AGE_WIDTH-1:0]  age_o,
  output logic [FREQ_WIDTH-1:0] freq_o,
  output logic [1:0]            wave_o,
  output logic                  retrig_o
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic                  active_q, active_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [FREQ_WIDTH-1:0] freq_q, freq_d;
  logic [1:0]            wave_q, wave_d;
  logic [AGE_WIDTH-1:0]  age_q, age_d;
  logic                  retrig_q, retrig_d;
  logic                  load;

  assign load = commit_on_i && sel_i;

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    freq_d   = freq_q;
    wave_d   = wave_q;
    age_d    = age_q;
    retrig_d = load;
    if (load) begin
      active_d = 1'b1;
      note_d   = note_i;
      freq_d   = freq_i;
      wave_d   = wave_i;
      age_d    = '0;
    end else if (commit_on_i && active_q && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_WIDTH'(1);
    end
    // Release keeps freq/wave; the mixer gates on the active flag.
    if (commit_off_i && sel_i) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      note_q   <= '0;
      freq_q   <= '0;
      wave_q   <= WAVE_SQUARE;
      age_q    <= '0;
      retrig_q <= 1'b0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      freq_q   <= freq_d;
      wave_q   <= wave_d;
      age_q    <= age_d;
      retrig_q <= retrig_d;
    end
  end

  assign active_o = active_q;
  assign match_o  = active_q && (note_q == note_i);
  assign age_o    = age_q;
  assign freq_o   = freq_q;
  assign wave_o   = wave_q;
  assign retrig_o = retrig_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: accepts note events, scans one voice per cycle to find
// a match / free / oldest voice, then commits the event to the chosen slot.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_WIDTH = DEFAULT_FREQ_WIDTH,
  parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                             Clock,
  input  logic                             Reset_n,
  input  logic                             NoteValid,
  output logic                             NoteReady,
  input  logic                             NoteOn,
  input  logic [NOTE_WIDTH-1:0]            NoteNum,
  input  logic [FREQ_WIDTH-1:0]            NoteFreq,
  input  logic [1:0]                       NoteWave,
  output logic [NUM_VOICES-1:0]            VoiceActive,
  output logic [NUM_VOICES*FREQ_WIDTH-1:0] VoiceFrequency,
  output logic [NUM_VOICES*2-1:0]          VoiceWaveType,
  output logic [NUM_VOICES-1:0]            VoiceRetrigger
);

  localparam int IDX_W = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e state_q, state_d;
  logic accept, commit_on, commit_off;

  logic                  ev_on_q;
  logic [NOTE_WIDTH-1:0] ev_note_q;
  logic [FREQ_WIDTH-1:0] ev_freq_q;
  logic [1:0]            ev_wave_q;

  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic                 match_found_q, match_found_d;
  logic [IDX_W-1:0]     match_idx_q, match_idx_d;
  logic                 free_found_q, free_found_d;
  logic [IDX_W-1:0]     free_idx_q, free_idx_d;
  logic                 oldest_found_q, oldest_found_d;
  logic [IDX_W-1:0]     oldest_idx_q, oldest_idx_d;
  logic [AGE_WIDTH-1:0] oldest_age_q, oldest_age_d;
  logic [IDX_W-1:0]     target_idx;

  logic [NUM_VOICES-1:0] slot_active;
  logic [NUM_VOICES-1:0] slot_match;
  logic [NUM_VOICES-1:0] slot_sel;
  logic [AGE_WIDTH-1:0]  slot_age [NUM_VOICES];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SCAN;
      ST_SCAN:   if (scan_idx_q == LAST_IDX) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    NoteReady  = (state_q == ST_IDLE);
    accept     = NoteValid && (state_q == ST_IDLE);
    commit_on  = (state_q == ST_COMMIT) && ev_on_q;
    commit_off = (state_q == ST_COMMIT) && !ev_on_q && match_found_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_freq_q <= '0;
      ev_wave_q <= WAVE_SQUARE;
    end else if (accept) begin
      ev_on_q   <= NoteOn;
      ev_note_q <= NoteNum;
      ev_freq_q <= NoteFreq;
      ev_wave_q <= NoteWave;
    end
  end

  // Scan trackers are cleared on accept and refined one voice per SCAN cycle.
  always_comb begin
    scan_idx_d     = scan_idx_q;
    match_found_d  = match_found_q;
    match_idx_d    = match_idx_q;
    free_found_d   = free_found_q;
    free_idx_d     = free_idx_q;
    oldest_found_d = oldest_found_q;
    oldest_idx_d   = oldest_idx_q;
    oldest_age_d   = oldest_age_q;
    if (accept) begin
      scan_idx_d     = '0;
      match_found_d  = 1'b0;
      match_idx_d    = '0;
      free_found_d   = 1'b0;
      free_idx_d     = '0;
      oldest_found_d = 1'b0;
      oldest_idx_d   = '0;
      oldest_age_d   = '0;
    end else if (state_q == ST_SCAN) begin
      if (scan_idx_q != LAST_IDX) begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      if (slot_match[scan_idx_q]) begin
        match_found_d = 1'b1;
        match_idx_d   = scan_idx_q;
      end
      if (!slot_active[scan_idx_q] && !free_found_q) begin
        free_found_d = 1'b1;
        free_idx_d   = scan_idx_q;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (slot_active[scan_idx_q] &&
          (!oldest_found_q || (slot_age[scan_idx_q] > oldest_age_q))) begin
        oldest_found_d = 1'b1;
        oldest_idx_d   = scan_idx_q;
        oldest_age_d   = slot_age[scan_idx_q];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      scan_idx_q     <= '0;
      match_found_q  <= 1'b0;
      match_idx_q    <= '0;
      free_found_q   <= 1'b0;
      free_idx_q     <= '0;
      oldest_found_q <= 1'b0;
      oldest_idx_q   <= '0;
      oldest_age_q   <= '0;
    end else begin
      scan_idx_q     <= scan_idx_d;
      match_found_q  <= match_found_d;
      match_idx_q    <= match_idx_d;
      free_found_q   <= free_found_d;
      free_idx_q     <= free_idx_d;
      oldest_found_q <= oldest_found_d;
      oldest_idx_q   <= oldest_idx_d;
      oldest_age_q   <= oldest_age_d;
    end
  end

  always_comb begin
    if (match_found_q) begin
      target_idx = match_idx_q;
    end else if (free_found_q) begin
      target_idx = free_idx_q;
    end else begin
      target_idx = oldest_idx_q;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign slot_sel[gi] = (target_idx == IDX_W'(gi));

      voice_slot #(
        .FREQ_WIDTH (FREQ_WIDTH),
        .NOTE_WIDTH (NOTE_WIDTH),
        .AGE_WIDTH  (AGE_WIDTH)
      ) u_slot (
        .clk_i        (Clock),
        .rst_ni       (Reset_n),
        .commit_on_i  (commit_on),
        .commit_off_i (commit_off),
        .sel_i        (slot_sel[gi]),
        .note_i       (ev_note_q),
        .freq_i       (ev_freq_q),
        .wave_i       (ev_wave_q),
        .active_o     (slot_active[gi]),
        .match_o      (slot_match[gi]),
        .age_o        (slot_age[gi]),
        .freq_o       (VoiceFrequency[gi*FREQ_WIDTH +: FREQ_WIDTH]),
        .wave_o       (VoiceWaveType[gi*2 +: 2]),
        .retrig_o     (VoiceRetrigger[gi])
      );
    end
  endgenerate

  assign VoiceActive = slot_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed tables, hand-written corner sequences and
// random events checked against an array-based allocation model.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int FW = 8;
  localparam int NW = 7;
  localparam int AW = 4;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              NoteValid = 1'b0;
  logic              NoteReady;
  logic              NoteOn = 1'b0;
  logic [NW-1:0]     NoteNum = '0;
  logic [FW-1:0]     NoteFreq = '0;
  logic [1:0]        NoteWave = '0;
  logic [NV-1:0]     VoiceActive;
  logic [NV*FW-1:0]  VoiceFrequency;
  logic [NV*2-1:0]   VoiceWaveType;
  logic [NV-1:0]     VoiceRetrigger;

  voice_allocator #(.NUM_VOICES(NV), .FREQ_WIDTH(FW), .NOTE_WIDTH(NW), .AGE_WIDTH(AW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .NoteValid(NoteValid), .NoteReady(NoteReady),
    .NoteOn(NoteOn), .NoteNum(NoteNum), .NoteFreq(NoteFreq), .NoteWave(NoteWave),
    .VoiceActive(VoiceActive), .VoiceFrequency(VoiceFrequency),
    .VoiceWaveType(VoiceWaveType), .VoiceRetrigger(VoiceRetrigger)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: plain per-voice arrays
  bit m_act [NV];
  int m_note [NV];
  int m_freq [NV];
  int m_wave [NV];
  int m_age [NV];

  typedef struct {
    bit on;
    int num;
    int freq;
    int wave;
    int exp_tgt;   // voice that must pulse, -1 = none
    int exp_act;   // VoiceActive after the event
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_freq[i] = 0; m_wave[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic int model_event(bit on, int num, int freq, int wave);
    int hit = -1;
    int tgt;
    for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == num) hit = i;
    if (!on) begin
      if (hit >= 0) m_act[hit] = 0;
      return hit;
    end
    tgt = hit;
    if (tgt < 0) for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) tgt = i;
    if (tgt < 0) begin
      tgt = 0;
      for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
    end
    for (int i = 0; i < NV; i++) begin
      if (i == tgt) begin
        m_act[i] = 1; m_note[i] = num; m_freq[i] = freq; m_wave[i] = wave; m_age[i] = 0;
      end else if (m_act[i]) begin
        m_age[i] = (m_age[i] + 1 > AGE_SAT) ? AGE_SAT : m_age[i] + 1;
      end
    end
    return tgt;
  endfunction

  function automatic logic [NV-1:0] exp_active();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [NV*FW-1:0] exp_freq();
    logic [NV*FW-1:0] v;
    for (int i = 0; i < NV; i++) v[i*FW +: FW] = FW'(m_freq[i]);
    return v;
  endfunction

  function automatic logic [NV*2-1:0] exp_wave();
    logic [NV*2-1:0] v;
    for (int i = 0; i < NV; i++) v[i*2 +: 2] = 2'(m_wave[i]);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    NoteValid = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    model_reset();
  endtask

  // exp_tgt = -2 / exp_act = -1 skip the table-constant checks
  task automatic do_event(input bit on, input int num, input int freq, input int wave,
                          input int exp_tgt, input int exp_act, input string tag);
    logic [NV-1:0]    pre_act;
    logic [NV*FW-1:0] pre_freq;
    logic [NV-1:0]    exp_pulse;
    int tgt, low_cnt, early;
    for (int k = 0; k < 20 && !NoteReady; k++) @(negedge Clock);
    if (!NoteReady) begin
      check({tag, " ready_wait"}, 64'(NoteReady), 64'd1);
      return;
    end
    NoteValid = 1'b1; NoteOn = on; NoteNum = NW'(num); NoteFreq = FW'(freq); NoteWave = 2'(wave);
    pre_act = VoiceActive;
    pre_freq = VoiceFrequency;
    @(negedge Clock);
    NoteValid = 1'b0;
    NoteNum = NW'($urandom);
    NoteFreq = FW'($urandom);
    tgt = model_event(on, num, freq, wave);
    exp_pulse = (on && tgt >= 0) ? NV'(1 << tgt) : '0;
    low_cnt = 0;
    early = 0;
    while (!NoteReady && low_cnt < 20) begin
      low_cnt++;
      if (VoiceActive !== pre_act || VoiceFrequency !== pre_freq || VoiceRetrigger !== '0)
        early++;
      @(negedge Clock);
    end
    $display("event %s on=%0d num=%0d freq=%0h wave=%0d -> model voice %0d", tag, on, num, freq, wave, tgt);
    check({tag, " cycles_per_event"}, 64'(low_cnt + 1), 64'(NV + 2));
    check({tag, " early_change"}, 64'(early), 64'd0);
    check({tag, " retrigger"}, 64'(VoiceRetrigger), 64'(exp_pulse));
    check({tag, " active"}, 64'(VoiceActive), 64'(exp_active()));
    check({tag, " freq"}, 64'(VoiceFrequency), 64'(exp_freq()));
    check({tag, " wave"}, 64'(VoiceWaveType), 64'(exp_wave()));
    if (exp_tgt != -2)
      check({tag, " tab_retrigger"}, 64'(VoiceRetrigger),
            64'((on && exp_tgt >= 0) ? (1 << exp_tgt) : 0));
    if (exp_act >= 0)
      check({tag, " tab_active"}, 64'(VoiceActive), 64'(exp_act));
    @(negedge Clock);
    check({tag, " pulse_width"}, 64'(VoiceRetrigger), 64'd0);
  endtask

  task automatic run_table(input vec_t tab[$], input string tag);
    foreach (tab[i])
      do_event(tab[i].on, tab[i].num, tab[i].freq, tab[i].wave,
               tab[i].exp_tgt, tab[i].exp_act, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    vec_t basic[$];
    vec_t steal[$];
    int quiet_bad;

    basic.push_back('{1, 60, 'h0F, 2, 0, 'b0001});
    basic.push_back('{1, 64, 'h13, 1, 1, 'b0011});
    basic.push_back('{1, 60, 'h10, 2, 0, 'b0011});

    steal.push_back('{1, 60, 'h20, 0, 0, 'b0001});
    steal.push_back('{1, 62, 'h22, 1, 1, 'b0011});
    steal.push_back('{1, 64, 'h24, 2, 2, 'b0111});
    steal.push_back('{1, 65, 'h25, 3, 3, 'b1111});
    steal.push_back('{1, 67, 'h27, 1, 0, 'b1111});
    steal.push_back('{0, 62, 'h00, 0, -1, 'b1101});
    steal.push_back('{0, 99, 'h00, 0, -1, 'b1101});
    steal.push_back('{1, 70, 'h30, 2, 1, 'b1111});
    steal.push_back('{1, 72, 'h32, 3, 2, 'b1111});   // ages 3,2,1 after 67 make voice 2 oldest here
    steal.push_back('{1, 74, 'h34, 0, 3, 'b1111});

    do_reset();
    @(negedge Clock);
    check("reset active", 64'(VoiceActive), 64'd0);
    check("reset ready", 64'(NoteReady), 64'd1);
    check("reset freq", 64'(VoiceFrequency), 64'd0);
    check("reset wave", 64'(VoiceWaveType), 64'd0);
    check("reset retrig", 64'(VoiceRetrigger), 64'd0);

    run_table(basic, "basic");
    check("basic v0 freq", 64'(VoiceFrequency[7:0]), 64'h10);
    check("basic v1 freq", 64'(VoiceFrequency[15:8]), 64'h13);

    do_reset();
    run_table(steal, "steal");

    // Age saturation plus tie-break: voices 0 and 1 both end at the ceiling
    do_reset();
    do_event(1, 10, 'h01, 0, 0, 'b0001, "sat_a");
    do_event(1, 11, 'h02, 0, 1, 'b0011, "sat_b");
    for (int i = 0; i < 14; i++) do_event(1, 12, 'h03 + i, 1, 2, 'b0111, $sformatf("sat_r%0d", i));
    do_event(1, 13, 'h40, 2, 3, 'b1111, "sat_c");
    do_event(1, 14, 'h41, 3, 0, 'b1111, "sat_steal0");
    do_event(1, 15, 'h42, 3, 1, 'b1111, "sat_steal1");

    // Reset during SCAN drops the in-flight event
    do_reset();
    do_event(1, 60, 'h0F, 2, 0, 'b0001, "mid_pre");
    @(negedge Clock);
    NoteValid = 1'b1; NoteOn = 1'b1; NoteNum = 7'd61; NoteFreq = 8'h55; NoteWave = 2'd3;
    @(negedge Clock);
    NoteValid = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    check("midreset active", 64'(VoiceActive), 64'd0);
    check("midreset ready", 64'(NoteReady), 64'd1);
    check("midreset freq", 64'(VoiceFrequency), 64'd0);
    Reset_n = 1'b1;
    model_reset();
    quiet_bad = 0;
    for (int i = 0; i < NV + 4; i++) begin
      @(negedge Clock);
      if (VoiceRetrigger !== '0 || VoiceActive !== '0 || !NoteReady) quiet_bad++;
    end
    check("midreset lost_event", 64'(quiet_bad), 64'd0);
    do_event(1, 61, 'h66, 1, 0, 'b0001, "mid_post");

    // Random events on a small note range so matches and steals are common
    do_reset();
    for (int i = 0; i < 120; i++)
      do_event(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom_range(0, 255),
               $urandom_range(0, 3), -2, -1, $sformatf("rnd%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
